// File: rtl/vx_amo_pkg.sv
// Shared definitions for the atomic read-modify-write path: opcodes (also used by
// the LSU decode), engine states and the SC result codes.
package vx_amo_pkg;

  typedef enum logic [3:0] {
    AMO_ADD  = 4'h0,
    AMO_SWAP = 4'h1,
    AMO_XOR  = 4'h2,
    AMO_OR   = 4'h3,
    AMO_AND  = 4'h4,
    AMO_MIN  = 4'h5,
    AMO_MAX  = 4'h6,
    AMO_MINU = 4'h7,
    AMO_MAXU = 4'h8,
    AMO_LR   = 4'h9,
    AMO_SC   = 4'hA
  } amo_op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_RSP     = 3'd4
  } amo_state_t;

  localparam int SC_SUCCESS = 0;
  localparam int SC_FAIL    = 1;

  // Encodings 4'hB..4'hF are reserved; the engine answers them without touching memory.
  function automatic logic is_known_op(input logic [3:0] op);
    case (op)
      AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
      AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU, AMO_LR, AMO_SC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_cmp(input logic [3:0] op);
    return (op == AMO_MIN) || (op == AMO_MAX);
  endfunction

endpackage

// File: rtl/vx_amo_rmw_unit_if.sv
// Core-side request/response and data-cache port of the AMO engine, bundled as one bus.
interface vx_amo_rmw_unit_if #(
  parameter int DATAW = 32,
  parameter int ADDRW = 32,
  parameter int TAGW  = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [ADDRW-1:0] req_addr;
  logic [DATAW-1:0] req_data;
  logic [TAGW-1:0]  req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [DATAW-1:0] rsp_data;
  logic [TAGW-1:0]  rsp_tag;

  logic             mem_req_valid;
  logic             mem_req_ready;
  logic             mem_req_rw;
  logic [ADDRW-1:0] mem_req_addr;
  logic [DATAW-1:0] mem_req_data;
  logic             mem_rsp_valid;
  logic [DATAW-1:0] mem_rsp_data;

  // Environment side: the core issues requests and the cache serves memory.
  modport master (
    output req_valid, req_op, req_addr, req_data, req_tag, rsp_ready,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  req_ready, rsp_valid, rsp_data, rsp_tag,
           mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, req_tag, rsp_ready,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output req_ready, rsp_valid, rsp_data, rsp_tag,
           mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
  );
endinterface

// File: rtl/vx_amo_alu.sv
// Combinational AMO ALU: maps (op, old memory value, operand) to the value written back.
module vx_amo_alu
  import vx_amo_pkg::*;
#(
  parameter int DATAW = 32
) (
  input  logic [3:0]       op,
  input  logic [DATAW-1:0] old_val,
  input  logic [DATAW-1:0] operand,
  output logic [DATAW-1:0] result
);

  logic signed [DATAW:0] old_ext;
  logic signed [DATAW:0] opd_ext;
  logic                  ext_en;
  logic                  old_lt;
  logic                  old_gt;

  // One signed comparator covers both flavours: the extra bit copies the MSB only
  // for MIN/MAX and is zero for MINU/MAXU, turning the compare unsigned.
  always_comb begin
    ext_en  = is_signed_cmp(op);
    old_ext = {ext_en & old_val[DATAW-1], old_val};
    opd_ext = {ext_en & operand[DATAW-1], operand};
    old_lt  = old_ext < opd_ext;
    old_gt  = opd_ext < old_ext;
    result  = operand;
    case (op)
      AMO_ADD:            result = old_val + operand;
      AMO_SWAP:           result = operand;
      AMO_XOR:            result = old_val ^ operand;
      AMO_OR:             result = old_val | operand;
      AMO_AND:            result = old_val & operand;
      AMO_MIN, AMO_MINU:  result = old_lt ? old_val : operand;
      AMO_MAX, AMO_MAXU:  result = old_gt ? old_val : operand;
      default:            result = operand;
    endcase
  end

endmodule

// File: rtl/vx_amo_rmw_unit.sv
// Atomic read-modify-write engine between the LSU and the data-cache port, with one
// outstanding transaction and a single LR/SC reservation.
module vx_amo_rmw_unit
  import vx_amo_pkg::*;
#(
  parameter int DATAW = 32,
  parameter int ADDRW = 32,
  parameter int TAGW  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  vx_amo_rmw_unit_if.slave        bus,
  output logic                    busy
);

  amo_state_t       state, state_n;

  logic [3:0]       op_q, op_n;
  logic [DATAW-1:0] opd_q, opd_n;
  logic [ADDRW-1:0] addr_n;
  logic [TAGW-1:0]  tag_n;
  logic [DATAW-1:0] wdata_n;
  logic [DATAW-1:0] rsp_data_n;
  logic             rsv_valid_q, rsv_valid_n;
  logic [ADDRW-1:0] rsv_addr_q, rsv_addr_n;

  logic             req_ready_q;
  logic             busy_q;
  logic             rsp_valid_q;
  logic [DATAW-1:0] rsp_data_q;
  logic [TAGW-1:0]  rsp_tag_q;
  logic             mem_req_valid_q;
  logic             mem_req_rw_q;
  logic [ADDRW-1:0] mem_req_addr_q;
  logic [DATAW-1:0] mem_req_data_q;

  logic [DATAW-1:0] alu_result;

  vx_amo_alu #(
    .DATAW (DATAW)
  ) u_alu (
    .op      (op_q),
    .old_val (bus.mem_rsp_data),
    .operand (opd_q),
    .result  (alu_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // The address and tag output registers double as the request latches, so they
  // already hold steady for the whole transaction.
  always_comb begin
    state_n     = state;
    op_n        = op_q;
    opd_n       = opd_q;
    addr_n      = mem_req_addr_q;
    tag_n       = rsp_tag_q;
    wdata_n     = mem_req_data_q;
    rsp_data_n  = rsp_data_q;
    rsv_valid_n = rsv_valid_q;
    rsv_addr_n  = rsv_addr_q;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          op_n   = bus.req_op;
          opd_n  = bus.req_data;
          addr_n = bus.req_addr;
          tag_n  = bus.req_tag;
          if (bus.req_op == AMO_SC) begin
            rsv_valid_n = 1'b0;
            if (rsv_valid_q && (rsv_addr_q == bus.req_addr)) begin
              wdata_n    = bus.req_data;
              rsp_data_n = DATAW'(SC_SUCCESS);
              state_n    = ST_WR_REQ;
            end else begin
              rsp_data_n = DATAW'(SC_FAIL);
              state_n    = ST_RSP;
            end
          end else if (!is_known_op(bus.req_op)) begin
            rsp_data_n = '1;
            state_n    = ST_RSP;
          end else begin
            state_n = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        if (bus.mem_req_ready) begin
          state_n = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (bus.mem_rsp_valid) begin
          rsp_data_n = bus.mem_rsp_data;
          if (op_q == AMO_LR) begin
            rsv_valid_n = 1'b1;
            rsv_addr_n  = mem_req_addr_q;
            state_n     = ST_RSP;
          end else begin
            // The write is committed from here on, so it breaks a matching reservation.
            wdata_n = alu_result;
            if (mem_req_addr_q == rsv_addr_q) begin
              rsv_valid_n = 1'b0;
            end
            state_n = ST_WR_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        if (bus.mem_req_ready) begin
          state_n = ST_RSP;
        end
      end
      ST_RSP: begin
        if (bus.rsp_ready) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Every output is decoded from the next state, keeping them all flop-driven.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q            <= '0;
      opd_q           <= '0;
      rsv_valid_q     <= 1'b0;
      rsv_addr_q      <= '0;
      req_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_tag_q       <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_rw_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_data_q  <= '0;
    end else begin
      op_q            <= op_n;
      opd_q           <= opd_n;
      rsv_valid_q     <= rsv_valid_n;
      rsv_addr_q      <= rsv_addr_n;
      req_ready_q     <= (state_n == ST_IDLE);
      busy_q          <= (state_n != ST_IDLE);
      rsp_valid_q     <= (state_n == ST_RSP);
      rsp_data_q      <= rsp_data_n;
      rsp_tag_q       <= tag_n;
      mem_req_valid_q <= (state_n == ST_RD_REQ) || (state_n == ST_WR_REQ);
      mem_req_rw_q    <= (state_n == ST_WR_REQ);
      mem_req_addr_q  <= addr_n;
      mem_req_data_q  <= wdata_n;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_tag       = rsp_tag_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_rw    = mem_req_rw_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.mem_req_data  = mem_req_data_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_vx_amo_rmw_unit.sv
// Bench for vx_amo_rmw_unit: directed AMO/LR/SC cases, randomized stalled traffic
// against a word-level memory and reservation model, and reset during a write.
module tb_vx_amo_rmw_unit;
  import vx_amo_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  vx_amo_rmw_unit_if #(.DATAW(32), .ADDRW(32), .TAGW(8)) bus ();

  vx_amo_rmw_unit #(.DATAW(32), .ADDRW(32), .TAGW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [logic [31:0]];
  bit          m_rsv_v = 1'b0;
  logic [31:0] m_rsv_a = '0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic bit ref_known(input logic [3:0] op);
    return op <= 4'hA;
  endfunction

  function automatic logic [31:0] ref_amo(input logic [3:0] op, input logic [31:0] old_v,
                                          input logic [31:0] opd);
    int signed so, sd;
    so = old_v;
    sd = opd;
    case (op)
      AMO_ADD:  return old_v + opd;
      AMO_XOR:  return old_v ^ opd;
      AMO_OR:   return old_v | opd;
      AMO_AND:  return old_v & opd;
      AMO_MIN:  return (so < sd) ? old_v : opd;
      AMO_MAX:  return (so > sd) ? old_v : opd;
      AMO_MINU: return (old_v < opd) ? old_v : opd;
      AMO_MAXU: return (old_v > opd) ? old_v : opd;
      default:  return opd;
    endcase
  endfunction

  // One complete transaction, acting as both core and memory, starting from idle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [7:0] tag, input bit stall, input string name,
                        output logic [31:0] obs_rsp, output logic [31:0] obs_wdata);
    logic [31:0] old_v, exp_rsp, exp_wdata, p_addr, p_data, p_rsp;
    logic [7:0]  p_tag;
    logic        p_rw;
    bit          exp_rd, exp_wr, rd_pend, mreq_held, rsp_held, done;
    int          exp_lat, cyc, rd_cnt, wr_cnt, cd;
    old_v = '0; exp_rsp = '0; exp_wdata = '0; p_addr = '0; p_data = '0; p_rsp = '0;
    p_tag = '0; p_rw = 1'b0; exp_rd = 0; exp_wr = 0; exp_lat = 1;
    obs_rsp = '0; obs_wdata = '0;

    if (op == AMO_SC) begin
      if (m_rsv_v && m_rsv_a == addr) begin
        exp_wr = 1; exp_wdata = data; exp_rsp = 32'd0; exp_lat = 2;
      end else begin
        exp_rsp = 32'd1; exp_lat = 1;
      end
      m_rsv_v = 1'b0;
    end else if (!ref_known(op)) begin
      exp_rsp = 32'hFFFF_FFFF; exp_lat = 1;
    end else begin
      exp_rd = 1;
      if (!mem.exists(addr)) mem[addr] = $urandom;
      old_v = mem[addr];
      exp_rsp = old_v;
      if (op == AMO_LR) begin
        m_rsv_v = 1'b1; m_rsv_a = addr; exp_lat = 3;
      end else begin
        exp_wr = 1; exp_wdata = ref_amo(op, old_v, data); exp_lat = 4;
        if (m_rsv_a == addr) m_rsv_v = 1'b0;
      end
    end

    @(negedge clk);
    bus.rsp_ready = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
    check1({name, ".req_ready"}, bus.req_ready, 1'b1);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr;
    bus.req_data = data; bus.req_tag = tag;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_op = 4'($urandom); bus.req_addr = $urandom;
    bus.req_data = $urandom; bus.req_tag = 8'($urandom);

    cyc = 1; rd_cnt = 0; wr_cnt = 0; rd_pend = 0; cd = 0;
    mreq_held = 0; rsp_held = 0; done = 0;
    while (!done && cyc < 200) begin
      if (rd_pend) begin
        if (cd == 0) begin
          bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = old_v; rd_pend = 0;
        end else begin
          bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = $urandom; cd--;
        end
      end else begin
        bus.mem_rsp_valid = stall ? ($urandom_range(0, 3) == 0) : 1'b0;
        bus.mem_rsp_data  = $urandom;
      end

      if (mreq_held) begin
        check1({name, ".mreq_hold_valid"}, bus.mem_req_valid, 1'b1);
        check1({name, ".mreq_hold_rw"}, bus.mem_req_rw, p_rw);
        check32({name, ".mreq_hold_addr"}, bus.mem_req_addr, p_addr);
        check32({name, ".mreq_hold_data"}, bus.mem_req_data, p_data);
      end
      if (bus.mem_req_valid) begin
        if (!mreq_held) check32({name, ".mreq_addr"}, bus.mem_req_addr, addr);
        bus.mem_req_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.mem_req_ready) begin
          mreq_held = 0;
          if (bus.mem_req_rw) begin
            wr_cnt++;
            obs_wdata = bus.mem_req_data;
            if (exp_wr) check32({name, ".wdata"}, bus.mem_req_data, exp_wdata);
          end else begin
            rd_cnt++;
            rd_pend = 1;
            cd = stall ? int'($urandom_range(0, 3)) : 0;
          end
        end else begin
          mreq_held = 1; p_rw = bus.mem_req_rw;
          p_addr = bus.mem_req_addr; p_data = bus.mem_req_data;
        end
      end else begin
        mreq_held = 0;
        bus.mem_req_ready = stall ? 1'($urandom_range(0, 1)) : 1'b0;
      end

      if (rsp_held) begin
        check1({name, ".rsp_hold_valid"}, bus.rsp_valid, 1'b1);
        check32({name, ".rsp_hold_data"}, bus.rsp_data, p_rsp);
        check32({name, ".rsp_hold_tag"}, 32'(bus.rsp_tag), 32'(p_tag));
      end
      if (bus.rsp_valid) begin
        obs_rsp = bus.rsp_data;
        if (!rsp_held) begin
          check32({name, ".rsp_data"}, bus.rsp_data, exp_rsp);
          check32({name, ".rsp_tag"}, 32'(bus.rsp_tag), 32'(tag));
          check1({name, ".busy"}, busy, 1'b1);
          check32({name, ".reads"}, 32'(rd_cnt), 32'(exp_rd));
          check32({name, ".writes"}, 32'(wr_cnt), 32'(exp_wr));
          if (!stall) check32({name, ".latency"}, 32'(cyc), 32'(exp_lat));
        end
        bus.rsp_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.rsp_ready) begin
          done = 1; rsp_held = 0;
        end else begin
          rsp_held = 1; p_rsp = bus.rsp_data; p_tag = bus.rsp_tag;
        end
      end else begin
        rsp_held = 0;
        bus.rsp_ready = stall ? 1'($urandom_range(0, 1)) : 1'b0;
      end

      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    check1({name, ".completed"}, done, 1'b1);
    if (exp_wr) mem[addr] = exp_wdata;
  endtask

  initial begin
    logic [31:0] o_r, o_w, r_addr, r_data;
    logic [3:0]  r_op;

    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_data = '0;
    bus.req_tag = '0; bus.rsp_ready = 1'b0; bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    repeat (3) @(negedge clk);
    check1("rst.req_ready", bus.req_ready, 1'b1);
    check1("rst.busy", busy, 1'b0);
    check1("rst.rsp_valid", bus.rsp_valid, 1'b0);
    check1("rst.mem_req_valid", bus.mem_req_valid, 1'b0);
    check1("rst.mem_req_rw", bus.mem_req_rw, 1'b0);
    check32("rst.mem_req_addr", bus.mem_req_addr, 32'h0);
    check32("rst.mem_req_data", bus.mem_req_data, 32'h0);
    check32("rst.rsp_data", bus.rsp_data, 32'h0);
    check32("rst.rsp_tag", 32'(bus.rsp_tag), 32'h0);
    reset = 1'b1;

    mem[32'h10] = 32'hFFFF_FFFF;
    run_op(AMO_ADD, 32'h10, 32'h2, 8'h3C, 1'b0, "add", o_r, o_w);
    check32("add.old", o_r, 32'hFFFF_FFFF);
    check32("add.wrap", o_w, 32'h0000_0001);

    mem[32'h20] = 32'h8000_0000;
    run_op(AMO_MIN, 32'h20, 32'h1, 8'h01, 1'b0, "min", o_r, o_w);
    check32("min.w", o_w, 32'h8000_0000);
    mem[32'h20] = 32'h8000_0000;
    run_op(AMO_MINU, 32'h20, 32'h1, 8'h02, 1'b0, "minu", o_r, o_w);
    check32("minu.w", o_w, 32'h0000_0001);
    mem[32'h20] = 32'h8000_0000;
    run_op(AMO_MAX, 32'h20, 32'h1, 8'h03, 1'b0, "max", o_r, o_w);
    check32("max.w", o_w, 32'h0000_0001);
    mem[32'h20] = 32'h8000_0000;
    run_op(AMO_MAXU, 32'h20, 32'h1, 8'h04, 1'b0, "maxu", o_r, o_w);
    check32("maxu.w", o_w, 32'h8000_0000);

    mem[32'h40] = 32'h1234_5678;
    run_op(AMO_LR, 32'h40, 32'h0, 8'h10, 1'b0, "lr1", o_r, o_w);
    check32("lr1.rsp", o_r, 32'h1234_5678);
    run_op(AMO_SC, 32'h40, 32'h7, 8'h11, 1'b0, "sc1", o_r, o_w);
    check32("sc1.rsp", o_r, 32'h0);
    check32("sc1.w", o_w, 32'h7);
    run_op(AMO_SC, 32'h40, 32'h9, 8'h12, 1'b0, "sc2", o_r, o_w);
    check32("sc2.rsp", o_r, 32'h1);

    run_op(AMO_LR, 32'h40, 32'h0, 8'h20, 1'b0, "lr3", o_r, o_w);
    run_op(AMO_ADD, 32'h40, 32'h1, 8'h21, 1'b0, "add3", o_r, o_w);
    run_op(AMO_SC, 32'h40, 32'h5, 8'h22, 1'b0, "sc3", o_r, o_w);
    check32("sc3.rsp", o_r, 32'h1);

    run_op(AMO_LR, 32'h40, 32'h0, 8'h30, 1'b0, "lr4", o_r, o_w);
    run_op(AMO_ADD, 32'h80, 32'h1, 8'h31, 1'b0, "add4", o_r, o_w);
    run_op(AMO_SC, 32'h40, 32'h5, 8'h32, 1'b0, "sc4", o_r, o_w);
    check32("sc4.rsp", o_r, 32'h0);
    check32("sc4.w", o_w, 32'h5);

    run_op(4'hC, 32'h40, 32'h5, 8'h40, 1'b0, "unk", o_r, o_w);
    check32("unk.rsp", o_r, 32'hFFFF_FFFF);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 5))
        0:       r_op = AMO_LR;
        1:       r_op = AMO_SC;
        default: r_op = 4'($urandom_range(0, 15));
      endcase
      r_addr = 32'h40 + 32'($urandom_range(0, 3)) * 32'd4;
      case ($urandom_range(0, 4))
        0:       r_data = 32'h8000_0000;
        1:       r_data = 32'h7FFF_FFFF;
        2:       r_data = 32'hFFFF_FFFF;
        default: r_data = $urandom;
      endcase
      run_op(r_op, r_addr, r_data, 8'(i), 1'b1, $sformatf("rand%0d", i), o_r, o_w);
    end

    // Reset while the write request is being held off by the cache.
    mem[32'h100] = 32'h10;
    @(negedge clk);
    bus.rsp_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_req_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_op = AMO_ADD; bus.req_addr = 32'h100;
    bus.req_data = 32'h5; bus.req_tag = 8'h5A;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h10;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    check1("rstw.pre_valid", bus.mem_req_valid, 1'b1);
    check1("rstw.pre_rw", bus.mem_req_rw, 1'b1);
    reset = 1'b0;
    #1;
    check1("rstw.req_ready", bus.req_ready, 1'b1);
    check1("rstw.busy", busy, 1'b0);
    check1("rstw.rsp_valid", bus.rsp_valid, 1'b0);
    check1("rstw.mem_req_valid", bus.mem_req_valid, 1'b0);
    check1("rstw.mem_req_rw", bus.mem_req_rw, 1'b0);
    check32("rstw.mem_req_addr", bus.mem_req_addr, 32'h0);
    check32("rstw.mem_req_data", bus.mem_req_data, 32'h0);
    check32("rstw.rsp_data", bus.rsp_data, 32'h0);
    check32("rstw.rsp_tag", 32'(bus.rsp_tag), 32'h0);
    bus.mem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_rsv_v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check1("rstw.no_write", bus.mem_req_valid, 1'b0);
    end
    run_op(AMO_ADD, 32'h100, 32'h3, 8'h77, 1'b0, "post_rst", o_r, o_w);
    check32("post_rst.old", o_r, 32'h10);
    check32("post_rst.w", o_w, 32'h13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vx_amo_rmw_unit.md
# vx_amo_rmw_unit

Parametrised atomic read-modify-write engine between the LSU and the data-cache port. It accepts one AMO/LR/SC request at a time and reads the old word. It computes the new value with a correctly signed ALU, writes the result back, and returns the old value tagged to the core. It generalises the single-cycle AMO ALU to arbitrary data/address widths and adds LR/SC reservation tracking and full valid/ready handshakes on both sides.

## Interface
- DATAW, 32: data word width (32 or 64).
- ADDRW, 32: address width.
- TAGW, 8: request tag width, returned unchanged.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- req_valid / req_ready  in / out  1  core request handshake.
- req_op  in  4  AMO opcode.
- req_addr  in  ADDRW  word address.
- req_data  in  DATAW  operand; SC store data.
- req_tag  in  TAGW  request tag.
- rsp_valid / rsp_ready  out / in  1  core response handshake.
- rsp_data  out  DATAW  old memory value; for SC, 0 = success, 1 = fail.
- rsp_tag  out  TAGW  echoed tag.
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake.
- mem_req_rw  out  1  1 = write.
- mem_req_addr  out  ADDRW  memory address.
- mem_req_data  out  DATAW  write data.
- mem_rsp_valid  in  1  read data valid; always accepted in RD_WAIT, ignored otherwise.
- mem_rsp_data  in  DATAW  read data.
- busy  out  1  state != IDLE.

## Operation
- Ops: ADD, SWAP, XOR, OR, AND, MIN, MAX, MINU, MAXU, LR, SC.
- Any other opcode: no memory access; response is all-ones.
- Old value = mem_rsp_data; operand = req_data, latched at accept.
- ADD wraps modulo 2^DATAW.
- MIN/MAX compare signed; MINU/MAXU compare unsigned.
  - Compare on DATAW+1 bits; the extension bit is the MSB only for signed ops.
  - MIN/MINU return old if old < operand, else operand; MAX/MAXU return the opposite. Equal operands return the operand.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, RSP.
  - IDLE: req_ready=1. On accept, latch op/addr/data/tag, then branch:
    - SC with reservation valid and address equal: go to WR_REQ.
    - SC otherwise: go to RSP with data 1.
    - Unknown op: go to RSP.
    - Anything else: go to RD_REQ.
  - RD_REQ: mem_req_valid=1, rw=0. On mem_req_ready, go to RD_WAIT.
  - RD_WAIT: on mem_rsp_valid, capture the old value.
    - LR: set reservation {valid, addr}, go to RSP.
    - Otherwise: register the ALU result, go to WR_REQ.
  - WR_REQ: mem_req_valid=1, rw=1, data = result (or SC data). On mem_req_ready, go to RSP. Writes are posted; there is no write ack.
  - RSP: rsp_valid=1. On rsp_ready, go to IDLE.
- Reservation clears on any SC (pass or fail) and on any AMO write to the reserved address.
- A reservation held from LR survives unrelated-address AMOs.
- mem_req_* and rsp_* hold stable while valid and not ready.

## Timing
- All outputs are registered.
- Reset values:
  - req_ready=1; busy=0.
  - rsp_valid, mem_req_valid, mem_req_rw = 0.
  - All data, address and tag outputs = 0.
  - Reservation invalid.
- Reset asserted mid-operation: immediate return to IDLE, transaction dropped, no write issued afterwards.
- Minimum AMO latency (zero-wait memory, rsp_ready=1):
  - Cycle 0: accept.
  - Cycle 1: read request.
  - Cycle 2: read data.
  - Cycle 3: write request.
  - Cycle 4: rsp_valid.
  - Cycle 5: next accept.
- LR minimum latency: rsp_valid at cycle 3. SC-fail and unknown op: rsp_valid at cycle 1.
- One outstanding transaction. Back-pressure on any handshake stalls the state indefinitely without loss.

## Structure
- Package vx_amo_pkg holds:
  - amo_op_t opcode enum, shared with the LSU decode.
  - amo_state_t.
  - SC_SUCCESS / SC_FAIL constants.
- Sub-module vx_amo_alu: combinational, parametrised by DATAW, maps (op, old, operand) to result. Reused by any future near-memory AMO path.
- Top level holds the FSM, the latches and the reservation register.

## Test plan
- ADD, DATAW=32: mem=0xFFFFFFFF, operand=2 -> rsp_data=0xFFFFFFFF, write 0x00000001, tag echoed.
- MIN vs MINU: old=0x80000000, operand=1 -> MIN writes 0x80000000; MINU writes 0x00000001. MAX/MAXU mirror this.
- LR then SC: LR addr 0x40 (rsp = mem value), SC addr 0x40 data 7 -> write 7, rsp 0. A second SC to 0x40 -> no memory access, rsp 1.
- LR 0x40, AMO ADD to 0x40, then SC 0x40 -> SC fails (rsp 1, no write). With AMO to 0x80 instead -> SC succeeds.
- Random mem_req_ready/rsp_ready stalls on 200 mixed ops -> results match the reference model, with outputs stable while stalled.
- Reset asserted during WR_REQ -> outputs at reset values immediately, no write observed, next request serviced normally.
